// File: rtl/cxu_responder.sv
// CXU responder: ADD/READ/CLEAR answer in 1 cycle, MAC in MUL_CYCLES+1, via an in-order response FIFO.
// Backpressure: cxu_req_ready (registered) drops while MAC runs or when every FIFO slot is taken.
module cxu_responder #(
    parameter int REQ_ID_W   = 3,
    parameter int CXU_ID_W   = 4,
    parameter int STATE_ID_W = 2,
    parameter int FUNC_ID_W  = 10,
    parameter int INSN_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STATUS_W   = 2,
    parameter int MY_CXU_ID  = 0,
    parameter int MUL_CYCLES = 4,
    parameter int RESP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cxu_req_valid,
    output logic                  cxu_req_ready,
    input  logic [REQ_ID_W-1:0]   cxu_req_id,
    input  logic [CXU_ID_W-1:0]   cxu_req_cxu,
    input  logic [STATE_ID_W-1:0] cxu_req_state,
    input  logic [FUNC_ID_W-1:0]  cxu_req_func,
    input  logic [INSN_W-1:0]     cxu_req_insn,
    input  logic [DATA_W-1:0]     cxu_req_data0,
    input  logic [DATA_W-1:0]     cxu_req_data1,
    output logic                  cxu_resp_valid,
    input  logic                  cxu_resp_ready,
    output logic [REQ_ID_W-1:0]   cxu_resp_id,
    output logic [STATUS_W-1:0]   cxu_resp_status,
    output logic [DATA_W-1:0]     cxu_resp_data
);
    localparam int NACC  = 2 ** STATE_ID_W;
    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int MC_W  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [CNT_W-1:0]     DEPTH    = CNT_W'(RESP_DEPTH);
    localparam logic [MC_W-1:0]      MC_LAST  = MC_W'(MUL_CYCLES - 1);
    localparam logic [CXU_ID_W-1:0]  MY_ID    = CXU_ID_W'(MY_CXU_ID);
    localparam logic [STATUS_W-1:0]  ST_OK    = STATUS_W'(0);
    localparam logic [STATUS_W-1:0]  ST_BFUNC = STATUS_W'(1);
    localparam logic [STATUS_W-1:0]  ST_BCXU  = STATUS_W'(2);
    localparam logic [FUNC_ID_W-1:0] F_ADD    = FUNC_ID_W'(0);
    localparam logic [FUNC_ID_W-1:0] F_MAC    = FUNC_ID_W'(1);
    localparam logic [FUNC_ID_W-1:0] F_READ   = FUNC_ID_W'(2);
    localparam logic [FUNC_ID_W-1:0] F_CLEAR  = FUNC_ID_W'(3);

    typedef enum logic {S_IDLE, S_MAC} state_e;

    state_e                state_q, state_d;
    logic [MC_W-1:0]       mc_q, mc_d;
    logic                  ready_q, ready_d;
    logic [REQ_ID_W-1:0]   mid_q, mid_d;
    logic [STATE_ID_W-1:0] mst_q, mst_d;
    logic [DATA_W-1:0]     ma_q, ma_d, mb_q, mb_d;
    logic [DATA_W-1:0]     acc_q [NACC];
    logic [DATA_W-1:0]     acc_d [NACC];

    logic [REQ_ID_W-1:0]   fid_q  [RESP_DEPTH];
    logic [STATUS_W-1:0]   fst_q  [RESP_DEPTH];
    logic [DATA_W-1:0]     fdat_q [RESP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  accept, push, pop;
    logic [REQ_ID_W-1:0]   push_id;
    logic [STATUS_W-1:0]   push_st;
    logic [DATA_W-1:0]     push_dat, mac_sum;
    logic                  unused_insn;

    assign unused_insn = ^cxu_req_insn;
    assign accept      = cxu_req_valid && ready_q;
    assign pop         = (count_q != '0) && cxu_resp_ready;
    assign mac_sum     = acc_q[mst_q] + ma_q * mb_q;

    always_comb begin
        state_d  = state_q;
        mc_d     = mc_q;
        mid_d    = mid_q;
        mst_d    = mst_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        push     = 1'b0;
        push_id  = cxu_req_id;
        push_st  = ST_OK;
        push_dat = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cxu_req_cxu != MY_ID) begin
                        push    = 1'b1;
                        push_st = ST_BCXU;
                    end else begin
                        case (cxu_req_func)
                            F_ADD: begin
                                push     = 1'b1;
                                push_dat = cxu_req_data0 + cxu_req_data1;
                            end
                            F_MAC: begin
                                mid_d   = cxu_req_id;
                                mst_d   = cxu_req_state;
                                ma_d    = cxu_req_data0;
                                mb_d    = cxu_req_data1;
                                mc_d    = MC_LAST;
                                state_d = S_MAC;
                            end
                            F_READ: begin
                                push     = 1'b1;
                                push_dat = acc_q[cxu_req_state];
                            end
                            F_CLEAR: begin
                                push                 = 1'b1;
                                push_dat             = acc_q[cxu_req_state];
                                acc_d[cxu_req_state] = '0;
                            end
                            default: begin
                                push    = 1'b1;
                                push_st = ST_BFUNC;
                            end
                        endcase
                    end
                end
            end
            S_MAC: begin
                // The slot for this push was reserved at admission, so it cannot overflow.
                if (mc_q == '0) begin
                    acc_d[mst_q] = mac_sum;
                    push         = 1'b1;
                    push_id      = mid_q;
                    push_dat     = mac_sum;
                    state_d      = S_IDLE;
                end else begin
                    mc_d = mc_q - MC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        ready_d = (state_d == S_IDLE) && (count_d < DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mc_q     <= '0;
            ready_q  <= 1'b0;
            mid_q    <= '0;
            mst_q    <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < NACC; i++) acc_q[i] <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                fid_q[i]  <= '0;
                fst_q[i]  <= '0;
                fdat_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            mc_q    <= mc_d;
            ready_q <= ready_d;
            mid_q   <= mid_d;
            mst_q   <= mst_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            if (push) begin
                fid_q[wr_ptr_q]  <= push_id;
                fst_q[wr_ptr_q]  <= push_st;
                fdat_q[wr_ptr_q] <= push_dat;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    assign cxu_req_ready   = ready_q;
    assign cxu_resp_valid  = (count_q != '0);
    assign cxu_resp_id     = fid_q[rd_ptr_q];
    assign cxu_resp_status = fst_q[rd_ptr_q];
    assign cxu_resp_data   = fdat_q[rd_ptr_q];
endmodule

// File: tb/tb_cxu_responder.sv
// Directed bench for cxu_responder with a response scoreboard and a small accumulator model.
module tb_cxu_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cxu_req_valid, cxu_req_ready;
    logic [2:0]  cxu_req_id;
    logic [3:0]  cxu_req_cxu;
    logic [1:0]  cxu_req_state;
    logic [9:0]  cxu_req_func;
    logic [31:0] cxu_req_insn, cxu_req_data0, cxu_req_data1;
    logic        cxu_resp_valid, cxu_resp_ready;
    logic [2:0]  cxu_resp_id;
    logic [1:0]  cxu_resp_status;
    logic [31:0] cxu_resp_data;

    always #5 clk = ~clk;

    cxu_responder dut (
        .clk(clk), .rst_n(rst_n),
        .cxu_req_valid(cxu_req_valid), .cxu_req_ready(cxu_req_ready),
        .cxu_req_id(cxu_req_id), .cxu_req_cxu(cxu_req_cxu),
        .cxu_req_state(cxu_req_state), .cxu_req_func(cxu_req_func),
        .cxu_req_insn(cxu_req_insn), .cxu_req_data0(cxu_req_data0),
        .cxu_req_data1(cxu_req_data1),
        .cxu_resp_valid(cxu_resp_valid), .cxu_resp_ready(cxu_resp_ready),
        .cxu_resp_id(cxu_resp_id), .cxu_resp_status(cxu_resp_status),
        .cxu_resp_data(cxu_resp_data)
    );

    typedef struct {
        logic [2:0]  id;
        logic [1:0]  st;
        logic [31:0] dat;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] m_acc [4];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at the falling edge: a response seen valid&ready here is consumed at the next rise.
    task automatic mon();
        rsp_t e;
        if (cxu_resp_valid && cxu_resp_ready) begin
            if (sb.size() == 0) begin
                fail("resp_unexpected", 32'(cxu_resp_id), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("resp_id", 32'(cxu_resp_id), 32'(e.id));
                chk("resp_status", 32'(cxu_resp_status), 32'(e.st));
                chk("resp_data", cxu_resp_data, e.dat);
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] id, input logic [3:0] cxu, input logic [1:0] st,
                        input logic [9:0] fn, input logic [31:0] a, input logic [31:0] b);
        rsp_t e;
        bit   done = 1'b0;
        cxu_req_id    = id;
        cxu_req_cxu   = cxu;
        cxu_req_state = st;
        cxu_req_func  = fn;
        cxu_req_data0 = a;
        cxu_req_data1 = b;
        cxu_req_insn  = $urandom;
        cxu_req_valid = 1'b1;
        for (int w = 0; w < 100 && !done; w++) begin
            @(negedge clk);
            mon();
            if (cxu_req_ready) begin
                e.id  = id;
                e.st  = 2'd0;
                e.dat = 32'd0;
                if (cxu != 4'd0) e.st = 2'd2;
                else case (fn)
                    10'd0: e.dat = a + b;
                    10'd1: begin m_acc[st] = m_acc[st] + a * b; e.dat = m_acc[st]; end
                    10'd2: e.dat = m_acc[st];
                    10'd3: begin e.dat = m_acc[st]; m_acc[st] = 32'd0; end
                    default: e.st = 2'd1;
                endcase
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        cxu_req_valid = 1'b0;
        if (!done) fail("req_accept_timeout", 32'(id), 32'(id));
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 100) begin
            cyc();
            w++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic mac_busy_check(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk(tag, 32'(cxu_req_ready), 32'd0);
            cyc();
        end
        chk(tag, 32'(cxu_req_ready), 32'd1);
    endtask

    initial begin
        foreach (m_acc[i]) m_acc[i] = 32'd0;
        rst_n = 1'b0;
        cxu_req_valid = 1'b0; cxu_req_id = '0; cxu_req_cxu = '0; cxu_req_state = '0;
        cxu_req_func = '0; cxu_req_insn = '0; cxu_req_data0 = '0; cxu_req_data1 = '0;
        cxu_resp_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(cxu_req_ready), 32'd0);
        chk("rst_resp_valid", 32'(cxu_resp_valid), 32'd0);
        chk("rst_resp_id", 32'(cxu_resp_id), 32'd0);
        chk("rst_resp_status", 32'(cxu_resp_status), 32'd0);
        chk("rst_resp_data", cxu_resp_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc();

        // ADD wraps; response visible one cycle after acceptance
        send(3'd5, 4'd0, 2'd0, 10'd0, 32'hFFFF_FFFF, 32'd2);
        chk("add_lat_valid", 32'(cxu_resp_valid), 32'd1);
        chk("add_lat_data", cxu_resp_data, 32'd1);
        drain();

        // Back-to-back MACs on state 1, each holding req_ready low for four cycles
        send(3'd1, 4'd0, 2'd1, 10'd1, 32'd3, 32'd4);
        mac_busy_check("mac1_ready");
        send(3'd2, 4'd0, 2'd1, 10'd1, 32'd5, 32'd6);
        mac_busy_check("mac2_ready");
        send(3'd0, 4'd0, 2'd0, 10'd1, 32'd2, 32'd10);
        drain();

        send(3'd3, 4'd0, 2'd1, 10'd3, 32'd0, 32'd0);
        send(3'd4, 4'd0, 2'd1, 10'd2, 32'd0, 32'd0);
        send(3'd6, 4'd0, 2'd0, 10'd2, 32'd0, 32'd0);
        drain();

        // Error statuses; wrong CXU wins over a bad function and a MAC never starts
        send(3'd1, 4'd0, 2'd0, 10'd7, 32'd9, 32'd9);
        send(3'd2, 4'd3, 2'd0, 10'd7, 32'd9, 32'd9);
        send(3'd3, 4'd3, 2'd2, 10'd1, 32'd9, 32'd9);
        chk("badcxu_mac_ready", 32'(cxu_req_ready), 32'd1);
        drain();

        // Fill the FIFO with the consumer stalled
        cxu_resp_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(3'(i), 4'd0, 2'd0, 10'd0, 32'(i) * 32'h1000_0001, 32'(i + 7));
        cxu_req_id = 3'd4; cxu_req_func = 10'd0; cxu_req_cxu = 4'd0;
        cxu_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("full_req_ready", 32'(cxu_req_ready), 32'd0);
            chk("full_head_id", 32'(cxu_resp_id), 32'd0);
        end
        cxu_req_valid = 1'b0;
        cxu_resp_ready = 1'b1;
        send(3'd4, 4'd0, 2'd0, 10'd0, 32'h0000_0100, 32'h0000_0023);
        drain();

        // Reset while a MAC is in flight with two responses queued
        send(3'd5, 4'd0, 2'd2, 10'd1, 32'd7, 32'd9);
        drain();
        cxu_resp_ready = 1'b0;
        send(3'd6, 4'd0, 2'd0, 10'd0, 32'd1, 32'd1);
        send(3'd7, 4'd0, 2'd0, 10'd0, 32'd2, 32'd2);
        send(3'd0, 4'd0, 2'd3, 10'd1, 32'd2, 32'd3);
        cyc();
        chk("pre_rst_busy", 32'(cxu_req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", 32'(cxu_resp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(cxu_req_ready), 32'd0);
        sb.delete();
        foreach (m_acc[i]) m_acc[i] = 32'd0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cxu_resp_ready = 1'b1;
        send(3'd1, 4'd0, 2'd2, 10'd2, 32'd0, 32'd0);
        send(3'd2, 4'd0, 2'd3, 10'd2, 32'd0, 32'd0);
        send(3'd3, 4'd0, 2'd0, 10'd2, 32'd0, 32'd0);
        drain();
        repeat (5) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
